countdown_tenth_ctrl: RTL
=========================

Name: countdown_tenth_ctrl

Overview:
Countdown-timer controller that sequences the free-running tenth-second counter for the puzzle alarm clock's timer/snooze function. It gates and re-phases the external tenth-second counter via counter_ena and counter_rst. It consumes that counter's terminal-count pulse and keeps a BCD MM:SS.t countdown value (max 99:59.9) for the display mux. On reaching zero it raises the alarm request.

Parameters:
AUTO_CLEAR_TENTHS, 0, 0 = alarm holds until clear/start; N>0 = alarm auto-drops after N tenth ticks, then go IDLE (max 65535).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tenth_sec_TC  in  1  one-cycle terminal-count pulse from the tenth-second counter
start  in  1  load and run (from IDLE or EXPIRED)
pause  in  1  toggle RUN<->PAUSE
clear  in  1  abort to IDLE and zero the digits
load_mt, load_mo, load_st, load_so, load_t  in  4 each  BCD load value: min tens, min ones, sec tens, sec ones, tenths
counter_ena  out  1  enable for the tenth-second counter
counter_rst  out  1  reset for the tenth-second counter
cur_mt, cur_mo, cur_st, cur_so, cur_t  out  4 each  current BCD countdown digits
state  out  2  IDLE=0, RUN=1, PAUSE=2, EXPIRED=3
done  out  1  one-cycle pulse on reaching zero
alarm  out  1  level alarm request
load_err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, and has highest priority.
- Reset values: state=IDLE, all digits 0, done=0, alarm=0, load_err=0, counter_ena=0, counter_rst=1, auto-clear counter 0.
- Input priority within one cycle: rst > clear > start > pause > tenth_sec_TC.
- IDLE: counter_ena=0, counter_rst=1.
  - start with valid load value: digits<=load value, go to RUN next cycle.
  - Valid means every digit <=9, load_st <=5, and the value is not all-zero.
  - start with invalid value: load_err=1 for one cycle, stay in IDLE, digits unchanged.
- RUN: counter_ena=1, counter_rst=0.
  - The start cycle has counter_rst=1, so the first tick arrives a full tenth after RUN is entered.
  - On tenth_sec_TC, decrement the BCD value; the registered digits update the cycle after the TC.
  - Borrow chain: t 0->9, so 0->9, st 0->5, mo 0->9, each with a borrow to the next digit; mt just decrements.
  - If the value before the TC is 00:00.1: digits become 0, go to EXPIRED, done=1 in that same update cycle.
  - pause: go to PAUSE. A TC in the same cycle is still applied, including the expiry case, which wins over pause.
- PAUSE: counter_ena=0, counter_rst=0, so the tick phase is preserved. TC is ignored. pause returns to RUN.
- EXPIRED: alarm=1, counter_ena=1, counter_rst=0; digits stay 0.
  - AUTO_CLEAR_TENTHS>0: count TCs. After N of them, alarm=0, go to IDLE, counter reset.
  - start with a valid value: reload, alarm=0, go to RUN. An invalid value gives load_err and leaves state and alarm unchanged.
- clear, any state: next cycle IDLE, digits 0, alarm 0, auto-clear counter 0. done is never asserted by clear.
- start while in RUN or PAUSE: ignored, no load_err.
- done and load_err are never high in the same cycle.

Decomposition:
- Shared package clock_pkg holds:
  - the state enum type (2-bit);
  - BCD limit constants (DIGIT_MAX=9, SEC_TENS_MAX=5);
  - a bcd_valid function used here and by the alarm-set block.
- One natural sub-module, bcd_down_digit: a 4-bit register with parameter MAX, ports borrow_in, load, load_val, clear and rst, outputs q and borrow_out (asserted when q==0 and borrow_in). It is instantiated five times.

Test Plan:
- Reset, then start with 00:01.2; inject TC every 10 cycles -> digits 00:01.1, 00:01.0, 00:00.9 ... 00:00.0. done pulses once after the 12th TC, state=3, alarm=1.
- Load 10:00.0 with one TC -> 09:59.9 (full borrow chain). Load 00:00.0 or 00:60.0 -> load_err pulse, state stays 0.
- Load 00:05.0, 3 TCs, pause, then 5 TCs -> digits hold 00:04.7 and counter_ena=0. Un-pause and 47 more TCs -> expiry.
- From 00:00.1, assert pause and TC in the same cycle -> EXPIRED with done=1, not PAUSE.
- AUTO_CLEAR_TENTHS=3: after expiry, 3 TCs -> alarm falls and state=0. With 0, alarm stays high until clear.
- clear mid-RUN at 00:03.4 -> next cycle state=0, digits 0, counter_rst=1. rst asserted together with start -> reset values win.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and helpers for the alarm-clock countdown/timer blocks.
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package clock_pkg;

  // Countdown controller state, encoded to match the external state port.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } cd_state_e;

  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Range check of an MM:SS.t BCD value. Zero is a legal time here; callers
  // that need a non-zero value check that separately.
  function automatic logic bcd_valid(input logic [3:0] mt,
                                     input logic [3:0] mo,
                                     input logic [3:0] st,
                                     input logic [3:0] so,
                                     input logic [3:0] t);
    bcd_valid = (mt <= DIGIT_MAX) && (mo <= DIGIT_MAX) &&
                (st <= SEC_TENS_MAX) && (so <= DIGIT_MAX) &&
                (t <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with borrow chaining, wrapping 0 -> MAX.
// Latency: q updates one clk after clear/load/borrow_in; borrow_out is combinational.
// Backpressure: none; every request is taken in the cycle it is presented.
//
// Ports: clk, rst (sync, active-high), clear (zero digit), load/load_val
// (parallel load), borrow_in (decrement request), q (digit), borrow_out
// (decrement request passed to the next more-significant digit).
module bcd_down_digit
  import clock_pkg::*;
#(
  parameter logic [3:0] MAX = DIGIT_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       borrow_in,
  output logic [3:0] q,
  output logic       borrow_out
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = 4'd0;
    end else if (load) begin
      q_d = load_val;
    end else if (borrow_in) begin
      q_d = (q_q == 4'd0) ? MAX : (q_q - 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q          = q_q;
  assign borrow_out = borrow_in && (q_q == 4'd0);

endmodule

// File: rtl/countdown_tenth_ctrl.sv
// Countdown timer controller: sequences the external tenth-second counter and
// keeps a BCD MM:SS.t value that counts down on its terminal-count pulse.
// Latency: all outputs registered, updating one clk after the causing input.
// Backpressure: none; inputs are single-cycle requests, resolved in the
// priority rst > clear > start > pause > tenth_sec_TC.
//
// Ports: clk, rst (sync, active-high); tenth_sec_TC tick input; start, pause,
// clear controls; load_* BCD load value; counter_ena/counter_rst to the tenth
// counter; cur_* BCD digits; state; done (expiry pulse); alarm (level);
// load_err (rejected-start pulse).
module countdown_tenth_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned AUTO_CLEAR_TENTHS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tenth_sec_TC,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [3:0] load_mt,
  input  logic [3:0] load_mo,
  input  logic [3:0] load_st,
  input  logic [3:0] load_so,
  input  logic [3:0] load_t,
  output logic       counter_ena,
  output logic       counter_rst,
  output logic [3:0] cur_mt,
  output logic [3:0] cur_mo,
  output logic [3:0] cur_st,
  output logic [3:0] cur_so,
  output logic [3:0] cur_t,
  output logic [1:0] state,
  output logic       done,
  output logic       alarm,
  output logic       load_err
);

  localparam logic [15:0] AC_N = 16'(AUTO_CLEAR_TENTHS);

  cd_state_e   state_q, state_d;
  logic        done_q, done_d;
  logic        alarm_q, alarm_d;
  logic        load_err_q, load_err_d;
  logic        counter_ena_q, counter_ena_d;
  logic        counter_rst_q, counter_rst_d;
  logic [15:0] ac_cnt_q, ac_cnt_d;

  logic load_ok;
  logic start_take;
  logic dig_load;
  logic dig_dec;
  logic at_one;
  logic expire;
  logic t_bo, so_bo, st_bo, mo_bo, mt_bo;

  assign load_ok = bcd_valid(load_mt, load_mo, load_st, load_so, load_t) &&
                   ({load_mt, load_mo, load_st, load_so, load_t} != 20'h0);

  // A start is only acted on (loaded or rejected) from IDLE or EXPIRED.
  assign start_take = !clear && start &&
                      ((state_q == ST_IDLE) || (state_q == ST_EXPIRED));
  assign dig_load   = start_take && load_ok;
  assign dig_dec    = !clear && (state_q == ST_RUN) && tenth_sec_TC;

  assign at_one = ({cur_mt, cur_mo, cur_st, cur_so, cur_t} == 20'h00001);
  // mt_bo can only fire on an underflow, which the non-zero load check makes
  // unreachable; it is folded in so a wrap can never keep the timer running.
  assign expire = dig_dec && (at_one || mt_bo);

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_dig_t (
    .clk(clk), .rst(rst), .clear(clear), .load(dig_load), .load_val(load_t),
    .borrow_in(dig_dec), .q(cur_t), .borrow_out(t_bo)
  );
  bcd_down_digit #(.MAX(DIGIT_MAX)) u_dig_so (
    .clk(clk), .rst(rst), .clear(clear), .load(dig_load), .load_val(load_so),
    .borrow_in(t_bo), .q(cur_so), .borrow_out(so_bo)
  );
  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_dig_st (
    .clk(clk), .rst(rst), .clear(clear), .load(dig_load), .load_val(load_st),
    .borrow_in(so_bo), .q(cur_st), .borrow_out(st_bo)
  );
  bcd_down_digit #(.MAX(DIGIT_MAX)) u_dig_mo (
    .clk(clk), .rst(rst), .clear(clear), .load(dig_load), .load_val(load_mo),
    .borrow_in(st_bo), .q(cur_mo), .borrow_out(mo_bo)
  );
  bcd_down_digit #(.MAX(DIGIT_MAX)) u_dig_mt (
    .clk(clk), .rst(rst), .clear(clear), .load(dig_load), .load_val(load_mt),
    .borrow_in(mo_bo), .q(cur_mt), .borrow_out(mt_bo)
  );

  always_comb begin
    state_d    = state_q;
    ac_cnt_d   = ac_cnt_q;
    done_d     = expire;
    load_err_d = start_take && !load_ok;

    if (clear) begin
      state_d  = ST_IDLE;
      ac_cnt_d = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dig_load) state_d = ST_RUN;
        end
        ST_RUN: begin
          // A tick that reaches zero wins over a simultaneous pause.
          if (expire)     state_d = ST_EXPIRED;
          else if (pause) state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (pause) state_d = ST_RUN;
        end
        ST_EXPIRED: begin
          if (dig_load) begin
            state_d  = ST_RUN;
            ac_cnt_d = 16'd0;
          end else if (!start && (AC_N != 16'd0) && tenth_sec_TC) begin
            if (ac_cnt_q == (AC_N - 16'd1)) begin
              state_d  = ST_IDLE;
              ac_cnt_d = 16'd0;
            end else begin
              ac_cnt_d = ac_cnt_q + 16'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Counter gating follows the state being entered, so it is registered in
    // step with state: held in reset while idle, frozen (phase kept) in PAUSE.
    alarm_d       = (state_d == ST_EXPIRED);
    counter_ena_d = (state_d == ST_RUN) || (state_d == ST_EXPIRED);
    counter_rst_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      done_q        <= 1'b0;
      alarm_q       <= 1'b0;
      load_err_q    <= 1'b0;
      counter_ena_q <= 1'b0;
      counter_rst_q <= 1'b1;
      ac_cnt_q      <= 16'd0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      alarm_q       <= alarm_d;
      load_err_q    <= load_err_d;
      counter_ena_q <= counter_ena_d;
      counter_rst_q <= counter_rst_d;
      ac_cnt_q      <= ac_cnt_d;
    end
  end

  assign state       = state_q;
  assign done        = done_q;
  assign alarm       = alarm_q;
  assign load_err    = load_err_q;
  assign counter_ena = counter_ena_q;
  assign counter_rst = counter_rst_q;

endmodule
